// File: rtl/cdb_pkg.sv
// Shared types and widths for the common data bus arbiter and its result buffers.
package cdb_pkg;

   localparam int CDB_VAL_W = 8;
   localparam int CDB_TAG_W = 4;
   localparam int CDB_ROB_W = 8;

   typedef struct packed {
      logic [CDB_VAL_W-1:0] val;
      logic [CDB_TAG_W-1:0] tag;
      logic [CDB_ROB_W-1:0] robid;
   } cdb_word_t;

   function automatic cdb_word_t make_word(input logic [CDB_VAL_W-1:0] val,
                                           input logic [CDB_TAG_W-1:0] tag,
                                           input logic [CDB_ROB_W-1:0] robid);
      cdb_word_t w;
      w.val   = val;
      w.tag   = tag;
      w.robid = robid;
      return w;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-FU result buffer: DEPTH-deep FIFO of cdb_word_t with an explicit occupancy count.
// The head is read combinationally so a grant can pop it into the output register the same edge.
module cdb_fifo
   import cdb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      flush,
   input  logic      push,
   input  cdb_word_t din,
   input  logic      pop,
   output cdb_word_t dout,
   output logic      full,
   output logic      empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   cdb_word_t         mem [DEPTH];
   logic [PW-1:0]     rd_ptr_reg;
   logic [PW-1:0]     wr_ptr_reg;
   logic [CW-1:0]     count_reg;

   // Storage has no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign dout  = mem[rd_ptr_reg];
   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common data bus arbiter: FU_COUNT buffered result ports, one registered broadcast per cycle.
// Optional macro CDB_BYPASS_EN lets a result arriving at an empty, winning FU skip its buffer.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int FU_COUNT  = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [FU_COUNT-1:0]                 fu_valid,
   input  logic [FU_COUNT-1:0][CDB_VAL_W-1:0]  fu_val,
   input  logic [FU_COUNT-1:0][CDB_TAG_W-1:0]  fu_tag,
   input  logic [FU_COUNT-1:0][CDB_ROB_W-1:0]  fu_robid,
   input  logic                                flush,
   output logic [FU_COUNT-1:0]                 fu_ready,
   output logic [CDB_VAL_W-1:0]                cdbval,
   output logic [CDB_TAG_W-1:0]                cdbid,
   output logic [CDB_ROB_W-1:0]                cdbrobid,
   output logic                                cdbtransmit
);

   localparam int PTR_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

   logic [FU_COUNT-1:0] full;
   logic [FU_COUNT-1:0] empty;
   logic [FU_COUNT-1:0] accept;
   logic [FU_COUNT-1:0] push;
   logic [FU_COUNT-1:0] pop;
   logic [FU_COUNT-1:0] req;
   cdb_word_t           head    [FU_COUNT];
   cdb_word_t           fu_word [FU_COUNT];

   logic [PTR_W-1:0]    rr_ptr_reg;
   logic [PTR_W-1:0]    rr_next;
   logic [PTR_W-1:0]    grant_idx;
   logic                grant_valid;
   cdb_word_t           out_word_reg;
   cdb_word_t           out_next;
   logic                transmit_reg;

   genvar gi;
   generate
      for (gi = 0; gi < FU_COUNT; gi++) begin : g_fu
         assign fu_word[gi] = make_word(fu_val[gi], fu_tag[gi], fu_robid[gi]);
         assign fu_ready[gi] = !full[gi];
         assign accept[gi]   = fu_valid[gi] && fu_ready[gi] && !flush;
`ifdef CDB_BYPASS_EN
         // An arriving result at an empty FU competes directly and is not buffered if it wins.
         assign req[gi]  = !empty[gi] || accept[gi];
         assign push[gi] = accept[gi] &&
                           !(grant_valid && (grant_idx == PTR_W'(gi)) && empty[gi]);
`else
         assign req[gi]  = !empty[gi];
         assign push[gi] = accept[gi];
`endif
         assign pop[gi] = grant_valid && (grant_idx == PTR_W'(gi)) && !empty[gi];

         cdb_fifo #(
            .DEPTH (BUF_DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[gi]),
            .din   (fu_word[gi]),
            .pop   (pop[gi]),
            .dout  (head[gi]),
            .full  (full[gi]),
            .empty (empty[gi])
         );
      end
   endgenerate

   // First requester at or after rr_ptr wins; a flush cycle grants nothing.
   always_comb begin
      int idx;
      idx         = 0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < FU_COUNT; k++) begin
         idx = (int'(rr_ptr_reg) + k) % FU_COUNT;
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = PTR_W'(idx);
         end
      end
      if (flush) begin
         grant_valid = 1'b0;
      end
   end

   always_comb begin
      rr_next = grant_idx + 1'b1;
      if (int'(grant_idx) == FU_COUNT - 1) begin
         rr_next = '0;
      end
   end

   always_comb begin
      out_next = head[grant_idx];
`ifdef CDB_BYPASS_EN
      if (empty[grant_idx]) begin
         out_next = fu_word[grant_idx];
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_reg   <= '0;
         out_word_reg <= '0;
         transmit_reg <= 1'b0;
      end else begin
         transmit_reg <= grant_valid;
         if (grant_valid) begin
            rr_ptr_reg   <= rr_next;
            out_word_reg <= out_next;
         end
      end
   end

   assign cdbval      = out_word_reg.val;
   assign cdbid       = out_word_reg.tag;
   assign cdbrobid    = out_word_reg.robid;
   assign cdbtransmit = transmit_reg;

endmodule
